timeout_timer_bank: RTL and testbench
=====================================

Name: timeout_timer_bank

Overview:
- Multi-channel, parametrised timeout timer bank: the next generation of the single-channel fixed-count timeout timer.
- Per-channel programmable due count; one-shot or periodic mode; sticky timeout flag with explicit clear; single-cycle expiry pulse.
- A prescaler is shared by all channels.
- Used by controller FSMs (NAND/PCIe command watchdogs) that each need an independent timeout.

Parameters:
- NUM_CH, 4, number of independent timer channels.
- CNT_W, 16, width of per-channel counter and due count.
- PRESCALE, 1, clock cycles per tick (>=1); 1 = tick every cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ch_start  in  NUM_CH  per-channel run enable (level); deassert to stop/abort.
- ch_mode  in  NUM_CH  0 = one-shot, 1 = periodic; sampled on entry to RUN and at each period boundary.
- due_cnt  in  NUM_CH*CNT_W  per-channel due count in ticks; channel i at [i*CNT_W +: CNT_W].
- timeout_clr  in  NUM_CH  per-channel clear of the sticky flag.
- timeout  out  NUM_CH  sticky expiry flag.
- timeout_pulse  out  NUM_CH  one-cycle pulse on each expiry.
- busy  out  NUM_CH  channel in RUN.
- any_timeout  out  1  OR of timeout[].

Behaviour:
- Reset (async, rst=1):
  - all channels go to IDLE; count = 0, due_lat = 0.
  - timeout, timeout_pulse, busy and any_timeout are 0.
  - prescaler counter is 0.
  - Reset mid-run aborts with no pulse.
- Prescaler:
  - free-running counter 0..PRESCALE-1; tick=1 in the cycle it equals PRESCALE-1, then wraps.
  - PRESCALE=1: tick is constantly 1.
  - Not restarted by ch_start, so first-period jitter is up to PRESCALE-1 cycles.
- Per-channel FSM, states IDLE, RUN, EXPIRED:
  - IDLE:
    - ch_start=1 -> RUN; count <= 0; due_lat <= (due_cnt==0 ? 1 : due_cnt).
    - due_cnt=0 is treated as 1.
  - RUN:
    - ch_start=0 -> IDLE; count <= 0; timeout is unchanged.
    - On tick with count < due_lat-1: count <= count+1.
    - On tick with count == due_lat-1 (expiry): timeout_pulse=1 for the next cycle, timeout <= 1, count <= 0.
    - Expiry in one-shot mode -> EXPIRED.
    - Expiry in periodic mode: stay in RUN and reload due_lat from the live due_cnt (0 -> 1) and ch_mode.
  - EXPIRED:
    - count held at 0; no further pulses.
    - ch_start=0 -> IDLE.
    - Restart requires ch_start to drop for at least one cycle.
- Latency: with PRESCALE=1, the RUN-entry edge is E0; the expiry edge is E0+D (D = due_lat), matching the legacy timer count.
  - timeout and timeout_pulse are visible after that edge.
- due_cnt changes during a period are ignored until the next boundary (latched).
- Counter never exceeds due_lat-1; no overflow at due_cnt = 2^CNT_W-1.
- Sticky flag:
  - timeout_clr=1 clears timeout next cycle.
  - Simultaneous expiry and clr in the same cycle: set wins (timeout stays 1).
  - clr does not affect state or count.
- timeout_pulse is registered, high exactly one cycle per expiry.
  - Periodic mode with D=1 and PRESCALE=1 gives a continuous pulse.
- busy = (state == RUN), registered with the state.
- any_timeout is combinational OR of the registered timeout[].
- Channels are fully independent; same-cycle events on different channels do not interact.

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, EXPIRED} tmr_state_e.
  - constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Sub-module timeout_timer_ch holds one channel's FSM, counter, due latch, sticky flag and pulse.
  - Parameter CNT_W; input tick.
  - Instantiated NUM_CH times by a generate loop.
- Prescaler lives in the top.

Test Plan:
1. PRESCALE=1, ch0 one-shot, due=5, ch_start=1 before edge 0 -> busy=1 after edge 0; timeout and timeout_pulse rise after edge 5; pulse drops after edge 6; state EXPIRED; busy=0.
2. ch1 periodic, due=3, ch_start held for 10 cycles -> pulses after edges 3, 6, 9; timeout stays 1; busy stays 1.
3. ch0 due=8, ch_start dropped after edge 4 -> IDLE, no pulse, timeout=0.
   - Restart with due=2 -> timeout after 2 edges.
4. timeout_clr asserted on the same cycle as a periodic expiry (due=4) -> timeout remains 1.
   - clr on the next cycle -> timeout=0 while the channel keeps running.
5. PRESCALE=4, due=3, due_cnt=0 on another channel -> expiry after 3 ticks (9-12 cycles depending on phase); due=0 channel expires on its first tick.
6. rst pulsed mid-run on all channels with mixed states -> every output 0 immediately (async), all channels IDLE, no pulse after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timeout timer bank.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } tmr_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timeout_timer_ch.sv
// One timer channel: FSM, tick counter, due latch, sticky flag and expiry pulse.
module timeout_timer_ch
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] due_i,
  input  logic             clr_i,
  output logic             timeout_o,
  output logic             pulse_o,
  output logic             busy_o
);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] due_q, due_d;
  logic             mode_q, mode_d;
  logic             timeout_q, timeout_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] due_fix_c;
  logic             expire_c;

  // A zero due count behaves as one tick.
  assign due_fix_c = (due_i == '0) ? CNT_W'(1) : due_i;
  assign expire_c  = (state_q == RUN) && start_i && tick_i &&
                     (count_q == due_q - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN: begin
        if (!start_i)                                 state_d = IDLE;
        else if (expire_c && mode_q == MODE_ONESHOT)  state_d = EXPIRED;
      end
      EXPIRED: if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    due_d     = due_q;
    mode_d    = mode_q;
    timeout_d = timeout_q & ~clr_i;
    pulse_d   = 1'b0;
    if (expire_c) begin
      timeout_d = 1'b1;
      pulse_d   = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d = '0;
          due_d   = due_fix_c;
          mode_d  = mode_i;
        end
      end
      RUN: begin
        if (!start_i) begin
          count_d = '0;
        end else if (expire_c) begin
          count_d = '0;
          if (mode_q == MODE_PERIODIC) begin
            due_d  = due_fix_c;
            mode_d = mode_i;
          end
        end else if (tick_i) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: count_d = '0;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      due_q     <= '0;
      mode_q    <= MODE_ONESHOT;
      timeout_q <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      due_q     <= due_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
    end
  end

  assign timeout_o = timeout_q;
  assign pulse_o   = pulse_q;
  assign busy_o    = busy_q;

endmodule

// File: rtl/timeout_timer_bank.sv
// Bank of independent timeout timers sharing one free-running prescaler.
module timeout_timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH*CNT_W-1:0] due_cnt,
  input  logic [NUM_CH-1:0]       timeout_clr,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       timeout_pulse,
  output logic [NUM_CH-1:0]       busy,
  output logic                    any_timeout
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic tick;

  if (PRESCALE <= 1) begin : g_no_ps
    assign tick = 1'b1;
  end else begin : g_ps
    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));
    assign ps_d = tick ? '0 : ps_q + PS_W'(1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ps_q <= '0;
      else     ps_q <= ps_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timeout_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .start_i   (ch_start[i]),
      .mode_i    (ch_mode[i]),
      .due_i     (due_cnt[i*CNT_W +: CNT_W]),
      .clr_i     (timeout_clr[i]),
      .timeout_o (timeout[i]),
      .pulse_o   (timeout_pulse[i]),
      .busy_o    (busy[i])
    );
  end

  assign any_timeout = |timeout;

endmodule

// File: tb/tb_timeout_timer_bank.sv
// Directed bench for timeout_timer_bank: PRESCALE=1 and PRESCALE=4 instances on shared inputs.
module tb_timeout_timer_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_start;
  logic [NUM_CH-1:0]       ch_mode;
  logic [NUM_CH*CNT_W-1:0] due_cnt;
  logic [NUM_CH-1:0]       timeout_clr;
  logic [NUM_CH-1:0]       timeout, timeout_pulse, busy;
  logic                    any_timeout;
  logic [NUM_CH-1:0]       ps_timeout, ps_pulse, ps_busy;
  logic                    ps_any;

  int n_checks = 0;
  int n_pass   = 0;

  timeout_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_mode(ch_mode),
    .due_cnt(due_cnt), .timeout_clr(timeout_clr), .timeout(timeout),
    .timeout_pulse(timeout_pulse), .busy(busy), .any_timeout(any_timeout)
  );

  timeout_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(4)) dut_ps (
    .clk(clk), .rst(rst), .ch_start(ch_start), .ch_mode(ch_mode),
    .due_cnt(due_cnt), .timeout_clr(timeout_clr), .timeout(ps_timeout),
    .timeout_pulse(ps_pulse), .busy(ps_busy), .any_timeout(ps_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_due(input int ch, input logic [CNT_W-1:0] v);
    due_cnt[ch*CNT_W +: CNT_W] = v;
  endtask

  task automatic clear_all();
    ch_start    = '0;
    timeout_clr = '1;
    step(1);
    timeout_clr = '0;
  endtask

  logic seen;

  initial begin
    rst = 1'b0; ch_start = '0; ch_mode = '0; due_cnt = '0; timeout_clr = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_pulse",   32'(timeout_pulse), 32'h0);
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_any",     32'(any_timeout), 32'h0);
    step(2);
    rst = 1'b0;

    // One-shot due=5; due change mid-period must be ignored.
    set_due(0, 16'd5); ch_start[0] = 1'b1;
    step(1);
    check("t1_busy_e0", 32'(busy[0]), 32'h1);
    set_due(0, 16'd2);
    step(4);
    check("t1_to_e4", 32'(timeout[0]), 32'h0);
    step(1);
    check("t1_to_e5",    32'(timeout[0]), 32'h1);
    check("t1_pulse_e5", 32'(timeout_pulse[0]), 32'h1);
    check("t1_busy_e5",  32'(busy[0]), 32'h0);
    step(1);
    check("t1_pulse_e6", 32'(timeout_pulse[0]), 32'h0);
    check("t1_any_e6",   32'(any_timeout), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen |= timeout_pulse[0] | busy[0];
    end
    check("t1_expired_quiet", 32'(seen), 32'h0);
    clear_all();
    check("t1_cleared", 32'(timeout[0]), 32'h0);

    // Periodic due=3: pulses after edges 3, 6, 9.
    set_due(1, 16'd3); ch_mode[1] = 1'b1; ch_start[1] = 1'b1;
    step(1);
    for (int e = 1; e <= 10; e++) begin
      step(1);
      check($sformatf("t2_pulse_e%0d", e), 32'(timeout_pulse[1]), 32'((e % 3) == 0));
      check($sformatf("t2_busy_e%0d", e), 32'(busy[1]), 32'h1);
    end
    check("t2_timeout", 32'(timeout[1]), 32'h1);
    clear_all();
    check("t2_stop_busy", 32'(busy[1]), 32'h0);
    ch_mode[1] = 1'b0;

    // Abort mid-run, then restart with due=2.
    set_due(0, 16'd8); ch_start[0] = 1'b1;
    step(5);
    ch_start[0] = 1'b0;
    step(1);
    check("t3_abort_busy", 32'(busy[0]), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen |= timeout_pulse[0];
    end
    check("t3_no_pulse", 32'(seen), 32'h0);
    check("t3_no_timeout", 32'(timeout[0]), 32'h0);
    set_due(0, 16'd2); ch_start[0] = 1'b1;
    step(2);
    check("t3_re_e1", 32'(timeout[0]), 32'h0);
    step(1);
    check("t3_re_e2_to", 32'(timeout[0]), 32'h1);
    check("t3_re_e2_pl", 32'(timeout_pulse[0]), 32'h1);
    clear_all();

    // Clear coinciding with a periodic expiry: set wins.
    set_due(2, 16'd4); ch_mode[2] = 1'b1; ch_start[2] = 1'b1;
    step(4);
    check("t4_e3", 32'(timeout[2]), 32'h0);
    timeout_clr[2] = 1'b1;
    step(1);
    check("t4_e4_setwins", 32'(timeout[2]), 32'h1);
    check("t4_e4_pulse",   32'(timeout_pulse[2]), 32'h1);
    step(1);
    check("t4_e5_cleared", 32'(timeout[2]), 32'h0);
    check("t4_e5_busy",    32'(busy[2]), 32'h1);
    timeout_clr[2] = 1'b0;
    step(3);
    check("t4_e8_to",    32'(timeout[2]), 32'h1);
    check("t4_e8_pulse", 32'(timeout_pulse[2]), 32'h1);
    clear_all();
    ch_mode[2] = 1'b0;

    // Periodic D=1 gives a continuous pulse; one-shot due=0 expires after one edge.
    set_due(3, 16'd1); ch_mode[3] = 1'b1; ch_start[3] = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("t_d1_pulse%0d", i), 32'(timeout_pulse[3]), 32'h1);
    end
    clear_all();
    set_due(3, 16'd0); ch_mode[3] = 1'b0; ch_start[3] = 1'b1;
    step(2);
    check("t_d0_pulse", 32'(timeout_pulse[3]), 32'h1);
    check("t_d0_busy",  32'(busy[3]), 32'h0);
    clear_all();

    // PRESCALE=4 from a known prescaler phase: ticks at edges 4, 8, 12 after release.
    rst = 1'b1; ch_start = '0;
    step(1);
    set_due(0, 16'd3); set_due(1, 16'd0); ch_mode = '0;
    ch_start[1:0] = 2'b11;
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      check($sformatf("t5_pulse_e%0d", e), 32'(ps_pulse[1:0]), 32'({e == 4, e == 12}));
    end
    check("t5_timeout", 32'(ps_timeout[1:0]), 32'h3);
    check("t5_busy",    32'(ps_busy[1:0]), 32'h0);
    clear_all();

    // Async reset with channels in mixed states.
    set_due(0, 16'd1);   ch_mode[0] = 1'b1;
    set_due(1, 16'd1);   ch_mode[1] = 1'b0;
    set_due(2, 16'd100); ch_mode[2] = 1'b1;
    set_due(3, 16'd2);   ch_mode[3] = 1'b0;
    ch_start = '1;
    step(4);
    check("t6_pre_any",   32'(any_timeout), 32'h1);
    check("t6_pre_pulse", 32'(timeout_pulse[0]), 32'h1);
    check("t6_pre_busy",  32'(busy[2]), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_timeout", 32'(timeout), 32'h0);
    check("t6_rst_pulse",   32'(timeout_pulse), 32'h0);
    check("t6_rst_busy",    32'(busy), 32'h0);
    check("t6_rst_any",     32'(any_timeout), 32'h0);
    check("t6_rst_ps",      32'({ps_timeout, ps_pulse, ps_busy}), 32'h0);
    ch_start = '0;
    step(1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      seen |= (|timeout_pulse) | (|busy) | (|timeout);
    end
    check("t6_post_quiet", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
